// File: rtl/cnn_read_responder.sv
// Single-beat-at-a-time AXI-style read responder for the CNN result memory and status registers.
// Optional build macro READ_RESP_SLVERR_EN: unmapped reads answer with SLVERR instead of OKAY.
module cnn_read_responder #(
  parameter logic [15:0] RESULT_NUM = 16'd8192
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  output logic        result_mem_read,
  output logic [15:0] result_mem_addr,
  input  logic [15:0] result_mem_data,
  input  logic [1:0]  image_set_register_data_output,
  input  logic        interrupt_register_data_output,
  output logic        result_read_done,
  output logic [2:0]  dbg_state
);

  // Handshakes: a transfer happens on a posedge where valid && ready; the
  // valid side holds its payload stable until that edge.
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_RESP} state_t;
  typedef enum logic [1:0] {R_RESULT, R_IMGSET, R_INTR, R_UNMAPPED} region_t;

`ifdef READ_RESP_SLVERR_EN
  localparam logic [1:0] UNMAPPED_RESP = 2'b10;
`else
  localparam logic [1:0] UNMAPPED_RESP = 2'b00;
`endif

  state_t      state_q, state_d;
  region_t     region_q, region_d, ar_region;
  logic [15:0] cur_addr_q, cur_addr_d;
  logic [7:0]  beats_left_q, beats_left_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [15:0] done_cnt_q, done_cnt_d, done_cnt_inc;
  logic        done_q, done_d;

  always_comb begin
    ar_region = R_UNMAPPED;
    if (araddr[31:16] == 16'hd000)   ar_region = R_RESULT;
    else if (araddr == 32'hd111_0000) ar_region = R_IMGSET;
    else if (araddr == 32'hd222_0000) ar_region = R_INTR;
  end

  assign done_cnt_inc = done_cnt_q + 16'd1;

  always_comb begin
    state_d      = state_q;
    region_d     = region_q;
    cur_addr_d   = cur_addr_q;
    beats_left_d = beats_left_q;
    rdata_d      = rdata_q;
    rresp_d      = rresp_q;
    done_cnt_d   = done_cnt_q;
    done_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arvalid) begin
          region_d     = ar_region;
          cur_addr_d   = araddr[15:0];
          beats_left_d = arlen;
          state_d      = (ar_region == R_RESULT) ? S_ISSUE : S_CAPTURE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        rdata_d = {{16{result_mem_data[15]}}, result_mem_data};
        rresp_d = 2'b00;
        state_d = S_RESP;
      end
      S_CAPTURE: begin
        case (region_q)
          R_IMGSET: begin rdata_d = {30'b0, image_set_register_data_output}; rresp_d = 2'b00; end
          R_INTR:   begin rdata_d = {31'b0, interrupt_register_data_output}; rresp_d = 2'b00; end
          default:  begin rdata_d = 32'd0; rresp_d = UNMAPPED_RESP; end
        endcase
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rready) begin
          // Only result beats count toward a complete readout.
          if (region_q == R_RESULT) begin
            if (done_cnt_inc == RESULT_NUM) begin
              done_cnt_d = 16'd0;
              done_d     = 1'b1;
            end else begin
              done_cnt_d = done_cnt_inc;
            end
          end
          if (beats_left_q == 8'd0) begin
            state_d = S_IDLE;
          end else begin
            beats_left_d = beats_left_q - 8'd1;
            cur_addr_d   = cur_addr_q + 16'd1;
            state_d      = (region_q == R_RESULT) ? S_ISSUE : S_CAPTURE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      region_q     <= R_RESULT;
      cur_addr_q   <= 16'd0;
      beats_left_q <= 8'd0;
      rdata_q      <= 32'd0;
      rresp_q      <= 2'b00;
      done_cnt_q   <= 16'd0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      region_q     <= region_d;
      cur_addr_q   <= cur_addr_d;
      beats_left_q <= beats_left_d;
      rdata_q      <= rdata_d;
      rresp_q      <= rresp_d;
      done_cnt_q   <= done_cnt_d;
      done_q       <= done_d;
    end
  end

  assign arready          = (state_q == S_IDLE);
  assign rvalid           = (state_q == S_RESP);
  assign rlast            = (state_q == S_RESP) && (beats_left_q == 8'd0);
  assign rdata            = rdata_q;
  assign rresp            = rresp_q;
  assign result_mem_read  = (state_q == S_ISSUE);
  assign result_mem_addr  = (state_q == S_ISSUE) ? cur_addr_q : 16'd0;
  assign result_read_done = done_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_cnn_read_responder.sv
// Randomized bench for cnn_read_responder against a transaction-level model of the read bus.
module tb_cnn_read_responder;
  localparam logic [15:0] RES_NUM = 16'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic        result_mem_read;
  logic [15:0] result_mem_addr;
  logic [15:0] result_mem_data;
  logic [1:0]  img;
  logic        intr;
  logic        result_read_done;
  logic [2:0]  dbg_state;

  int total = 0;
  int bad = 0;
  int model_cnt = 0;
  int done_pulses = 0;
  logic [15:0] mem [0:65535];
  logic [15:0] rd_addr_q[$];

`ifdef READ_RESP_SLVERR_EN
  localparam logic [1:0] EXP_UNMAPPED_RESP = 2'b10;
`else
  localparam logic [1:0] EXP_UNMAPPED_RESP = 2'b00;
`endif

  cnn_read_responder #(.RESULT_NUM(RES_NUM)) dut (
    .clk(clk), .rst(rst), .araddr(araddr), .arlen(arlen), .arvalid(arvalid),
    .arready(arready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready), .result_mem_read(result_mem_read), .result_mem_addr(result_mem_addr),
    .result_mem_data(result_mem_data), .image_set_register_data_output(img),
    .interrupt_register_data_output(intr), .result_read_done(result_read_done),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // External result memory: data appears one cycle after the strobe.
  always @(posedge clk) begin
    if (result_mem_read) begin
      result_mem_data <= mem[result_mem_addr];
      rd_addr_q.push_back(result_mem_addr);
    end
    if (result_read_done) done_pulses <= done_pulses + 1;
  end

  function automatic logic [31:0] model_data(input logic [31:0] a, input logic [15:0] cur);
    if (a[31:16] == 16'hd000) return 32'($signed(mem[cur]));
    if (a == 32'hd111_0000) return 32'(img);
    if (a == 32'hd222_0000) return 32'(intr);
    return 32'd0;
  endfunction

  function automatic logic [1:0] model_resp(input logic [31:0] a);
    if (a[31:16] == 16'hd000 || a == 32'hd111_0000 || a == 32'hd222_0000) return 2'b00;
    return EXP_UNMAPPED_RESP;
  endfunction

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len,
                         input int stall_lo, input int stall_hi);
    logic [15:0] cur;
    logic [15:0] got_addr;
    logic [31:0] ed;
    logic [1:0]  er;
    logic        exp_done;
    bit          res;
    int          n;
    int          stall;
    cur = addr[15:0];
    res = (addr[31:16] == 16'hd000);
    exp_done = 1'b0;
    @(negedge clk);
    total++;
    if (arready !== 1'b1) begin bad++; $display("FAIL arready_idle addr=%h got=%b exp=1", addr, arready); end
    arvalid = 1'b1; araddr = addr; arlen = len; rready = 1'b0;
    @(posedge clk);
    for (int b = 0; b <= int'(len); b++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (n == 1) begin
          // Junk request while busy must be ignored.
          arvalid = 1'b1; araddr = 32'hd000_1234; arlen = 8'd7;
          rready = 1'b0;
          img = 2'($urandom_range(0, 3)); intr = 1'($urandom_range(0, 1));
          total++;
          if (result_read_done !== exp_done) begin
            bad++; $display("FAIL done_pulse addr=%h beat=%0d got=%b exp=%b", addr, b, result_read_done, exp_done);
          end
        end
        if (!rvalid) begin
          total++;
          if (arready !== 1'b0) begin bad++; $display("FAIL arready_busy addr=%h got=%b exp=0", addr, arready); end
        end
      end while (!rvalid && n < 8);
      total++;
      if (n != (res ? 3 : 2)) begin
        bad++; $display("FAIL latency addr=%h beat=%0d got=%0d exp=%0d", addr, b, n, res ? 3 : 2);
      end
      if (!rvalid) begin
        arvalid = 1'b0;
        return;
      end
      ed = model_data(addr, cur);
      er = model_resp(addr);
      total++;
      if (rdata !== ed) begin bad++; $display("FAIL rdata addr=%h beat=%0d got=%h exp=%h", addr, b, rdata, ed); end
      total++;
      if (rresp !== er) begin bad++; $display("FAIL rresp addr=%h beat=%0d got=%b exp=%b", addr, b, rresp, er); end
      total++;
      if (rlast !== (b == int'(len))) begin bad++; $display("FAIL rlast addr=%h beat=%0d got=%b exp=%b", addr, b, rlast, b == int'(len)); end
      total++;
      if (rd_addr_q.size() != (res ? 1 : 0)) begin
        bad++; $display("FAIL mem_read_count addr=%h beat=%0d got=%0d exp=%0d", addr, b, rd_addr_q.size(), res ? 1 : 0);
      end
      if (res && rd_addr_q.size() > 0) begin
        got_addr = rd_addr_q.pop_front();
        total++;
        if (got_addr !== cur) begin bad++; $display("FAIL mem_addr beat=%0d got=%h exp=%h", b, got_addr, cur); end
      end
      rd_addr_q.delete();
      stall = $urandom_range(stall_hi, stall_lo);
      repeat (stall) begin
        @(negedge clk);
        total++;
        if (rvalid !== 1'b1 || rdata !== ed || rlast !== (b == int'(len)) || rresp !== er || rd_addr_q.size() != 0) begin
          bad++;
          $display("FAIL hold addr=%h beat=%0d got v=%b d=%h l=%b r=%b rd=%0d exp v=1 d=%h l=%b r=%b rd=0",
                   addr, b, rvalid, rdata, rlast, rresp, rd_addr_q.size(), ed, b == int'(len), er);
        end
      end
      rready = 1'b1;
      @(posedge clk);
      exp_done = 1'b0;
      if (res) begin
        model_cnt++;
        if (model_cnt == int'(RES_NUM)) begin
          exp_done = 1'b1;
          model_cnt = 0;
        end
      end
      cur = cur + 16'd1;
    end
    @(negedge clk);
    arvalid = 1'b0; rready = 1'b0;
    total++;
    if (result_read_done !== exp_done) begin bad++; $display("FAIL done_end addr=%h got=%b exp=%b", addr, result_read_done, exp_done); end
    total++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      bad++; $display("FAIL end_idle addr=%h got rvalid=%b arready=%b exp rvalid=0 arready=1", addr, rvalid, arready);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    total++;
    if (arready !== 1'b1 || rvalid !== 1'b0 || rlast !== 1'b0 || rresp !== 2'b00 || rdata !== 32'd0 ||
        result_mem_read !== 1'b0 || result_mem_addr !== 16'd0 || result_read_done !== 1'b0) begin
      bad++;
      $display("FAIL %s got ar=%b v=%b l=%b r=%b d=%h mr=%b ma=%h done=%b exp ar=1 rest=0", tag,
               arready, rvalid, rlast, rresp, rdata, result_mem_read, result_mem_addr, result_read_done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_state");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("after_reset_release");
  endtask

  task automatic test_single();
    mem[16'd5] = 16'h8001;
    do_read(32'hd000_0005, 8'd0, 0, 0);
  endtask

  task automatic test_burst_wrap();
    do_read(32'hd000_fffe, 8'd3, 0, 1);
  endtask

  task automatic test_backpressure();
    do_read(32'hd000_0100, 8'd1, 5, 5);
  endtask

  task automatic test_registers();
    do_read(32'hd111_0000, 8'd0, 0, 2);
    do_read(32'hd222_0000, 8'd0, 0, 2);
    do_read(32'hd111_0000, 8'd2, 0, 1);
    do_read(32'hd222_0000, 8'd2, 0, 1);
  endtask

  task automatic test_unmapped();
    do_read(32'hd999_0000, 8'd0, 0, 1);
    do_read(32'hd111_0004, 8'd1, 0, 1);
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    arvalid = 1'b1; araddr = 32'hd000_0010; arlen = 8'd3;
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_reset_async");
    @(negedge clk);
    check_reset_outputs("mid_reset_next");
    rst = 1'b0;
    model_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      total++;
      if (rvalid !== 1'b0 || result_mem_read !== 1'b0 || arready !== 1'b1) begin
        bad++; $display("FAIL post_reset_quiet got rvalid=%b mr=%b arready=%b exp 0 0 1", rvalid, result_mem_read, arready);
      end
    end
    total++;
    if (rd_addr_q.size() != 0) begin bad++; $display("FAIL post_reset_reads got=%0d exp=0", rd_addr_q.size()); end
    rd_addr_q.delete();
  endtask

  task automatic test_done();
    int start;
    start = done_pulses;
    do_read(32'hd000_0200, 8'd1, 0, 0);
    do_read(32'hd000_0300, 8'd1, 0, 0);
    @(negedge clk);
    total++;
    if (done_pulses - start != 1) begin bad++; $display("FAIL done_count got=%0d exp=1", done_pulses - start); end
  endtask

  task automatic test_random();
    logic [31:0] a;
    int sel;
    for (int i = 0; i < 24; i++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0: a = {16'hd000, 16'($urandom)};
        1: a = 32'hd111_0000;
        2: a = 32'hd222_0000;
        default: a = {4'he, 28'($urandom)};
      endcase
      do_read(a, 8'($urandom_range(0, 3)), 0, 3);
    end
  endtask

  initial begin
    arvalid = 1'b0; araddr = 32'd0; arlen = 8'd0; rready = 1'b0; img = 2'b00; intr = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    test_reset();
    test_single();
    test_burst_wrap();
    test_backpressure();
    test_registers();
    test_unmapped();
    test_mid_reset();
    test_done();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cnn_read_responder.md
CNN_READ_RESPONDER -- requirements
Module: cnn_read_responder

Interface
REQ-001 The block SHALL have parameter RESULT_NUM, default 16'd8192, meaning the number of result words in one complete result readout.
REQ-002 The block SHALL use reset rst, asynchronous, active-high, and clock clk.
REQ-003 Port clk, input, 1 bit: clock; all state updates on posedge.
REQ-004 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-005 Port araddr, input, 32 bits: read address.
REQ-006 Port arlen, input, 8 bits: burst length minus one.
REQ-007 Port arvalid, input, 1 bit: read address valid.
REQ-008 Port arready, output, 1 bit: read address accept.
REQ-009 Port rdata, output, 32 bits: read data.
REQ-010 Port rresp, output, 2 bits: read response.
REQ-011 Port rlast, output, 1 bit: final beat of the burst.
REQ-012 Port rvalid, output, 1 bit: read data valid.
REQ-013 Port rready, input, 1 bit: master accepts read data.
REQ-014 Port result_mem_read, output, 1 bit: result memory read strobe.
REQ-015 Port result_mem_addr, output, 16 bits: result memory element index.
REQ-016 Port result_mem_data, input, 16 bits: result memory data, valid one cycle after the strobe.
REQ-017 Port image_set_register_data_output, input, 2 bits: current image-set register value.
REQ-018 Port interrupt_register_data_output, input, 1 bit: current interrupt register value.
REQ-019 Port result_read_done, output, 1 bit: one-cycle pulse when a full result set has been delivered.

Function
REQ-020 Address decode SHALL be:
- araddr[31:16]==16'hd000: RESULT region; element index = araddr[15:0].
- araddr==32'hd111_0000: IMGSET.
- araddr==32'hd222_0000: INTR.
- anything else: UNMAPPED.
REQ-021 The FSM SHALL have states IDLE, ISSUE, WAIT, CAPTURE and RESP.
REQ-022 arready SHALL equal (state==IDLE), combinationally.
REQ-023 On arvalid&&arready the block SHALL latch the region, cur_addr=araddr[15:0], and beats_left=arlen, then go to ISSUE for RESULT and to CAPTURE for all other regions.
REQ-024 ISSUE SHALL assert result_mem_read=1 with result_mem_addr=cur_addr for exactly one cycle, then go to WAIT.
- Outside ISSUE: result_mem_read=0 and result_mem_addr=16'd0.
REQ-025 WAIT SHALL register rdata={{16{result_mem_data[15]}},result_mem_data} (sign-extended) and rresp=2'b00, then go to RESP.
REQ-026 CAPTURE SHALL register rdata and rresp, then go to RESP:
- IMGSET: rdata={30'b0,image_set_register_data_output}.
- INTR: rdata={31'b0,interrupt_register_data_output}.
- UNMAPPED: rdata=32'd0.
REQ-027 Latency SHALL be: address accept at cycle T gives rvalid at T+3 for RESULT and at T+2 for the other regions; each subsequent RESULT beat takes 3 cycles from the previous rvalid&&rready.
REQ-028 RESP SHALL hold rvalid=1 and keep rdata, rresp and rlast stable until rready=1.
REQ-029 rlast SHALL be (beats_left==0) while in RESP.
REQ-030 On rvalid&&rready in RESP:
- beats_left==0: go to IDLE.
- otherwise: beats_left-1 and cur_addr+1 (16-bit wrap, 16'hFFFF to 16'h0000), then ISSUE for RESULT or CAPTURE for register reads (the register is re-sampled each beat).
REQ-031 arvalid outside IDLE SHALL be ignored and not latched.
REQ-032 A 16-bit done counter SHALL increment on every accepted RESULT beat.
- When the counter reaches RESULT_NUM, result_read_done SHALL pulse high for one cycle and the counter SHALL clear to 0 in the same cycle.
REQ-033 Register and UNMAPPED beats SHALL NOT affect the done counter.

Reset
REQ-034 On rst, state SHALL be IDLE, the done counter 0, and arready=1.
- rvalid, rlast, rresp, rdata, result_mem_read, result_mem_addr and result_read_done SHALL all be 0.
REQ-035 rst mid-burst SHALL abort the burst immediately; no further beats are produced and no memory read is issued.

Configuration
REQ-036 With macro READ_RESP_SLVERR_EN defined, UNMAPPED beats SHALL return rresp=2'b10 and rdata=0.
REQ-037 Without READ_RESP_SLVERR_EN, UNMAPPED beats SHALL return rresp=2'b00 and rdata=0.
REQ-038 All other behaviour SHALL be identical with and without READ_RESP_SLVERR_EN.

Verification
REQ-039 Single read: araddr=32'hd000_0005, arlen=0, result_mem_data=16'h8001 -> result_mem_read at T+1 with addr 5; rvalid at T+3; rdata=32'hFFFF_8001, rresp=0, rlast=1.
REQ-040 Burst: araddr=32'hd000_FFFE, arlen=3 -> memory addresses FFFE, FFFF, 0000, 0001 in order; rlast only on the 4th beat.
REQ-041 Backpressure: rready=0 for 5 cycles -> rvalid, rdata and rlast held constant; no new result_mem_read until the beat is accepted.
REQ-042 Registers: image_set_register_data_output=2'b10, read 32'hd111_0000 -> rdata=2 at T+2; interrupt_register_data_output=1, read 32'hd222_0000 -> rdata=1; arready=0 throughout both transactions.
REQ-043 Unmapped: read 32'hd999_0000 -> rresp=2'b10 with READ_RESP_SLVERR_EN, 2'b00 without; rdata=0 in both cases.
REQ-044 Done and reset: RESULT_NUM=4, two bursts with arlen=1 -> result_read_done pulses once on the 4th accept; a separate test asserting rst mid-burst -> all outputs 0 and arready=1 on the next cycle.
